// File: rtl/machine_term_serializer.sv
// Streaming serializer for SKI machine terms: encodes one combinator term
// into a heap word and emits it most-significant beat first on a valid/ready bus.
module machine_term_serializer #(
  parameter int PTR_W = 30,
  parameter int OUT_W = 32,
  parameter int TAG_W = 4,
  parameter int BUS_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               system1000,
  input  logic               system1000_rstn,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_tag,
  input  logic [PTR_W-1:0]   in_a,
  input  logic [PTR_W-1:0]   in_b,
  input  logic [OUT_W-1:0]   in_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BUS_W-1:0]   out_data,
  output logic               out_first,
  output logic               out_last,
  output logic [CNT_W-1:0]   term_cnt,
  output logic               err_pulse,
  output logic               err_sticky
);

  localparam int ENC_W = TAG_W + 2 * PTR_W;
  localparam int BEATS = (ENC_W + BUS_W - 1) / BUS_W;
  localparam int SR_W  = BEATS * BUS_W;
  localparam int PP_W  = 2 * PTR_W;
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(BEATS - 1);
  localparam logic ONE_BEAT = (BEATS == 1);

  if (OUT_W > PP_W) begin : g_bad_out_w
    $error("OUT_W must not exceed 2*PTR_W");
  end

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t            state;
  logic [SR_W-1:0]   sr;
  logic [BI_W-1:0]   beat_idx;
  logic [SR_W-1:0]   enc;
  logic [TAG_W-1:0]  tag_ext;
  logic              legal;
  logic              accept;

  assign legal  = (in_tag <= 3'd4);
  assign accept = in_valid && in_ready;

  // A new term may enter while idle or as the final beat leaves.
  assign in_ready = system1000_rstn && !clr &&
                    ((state == IDLE) || (out_last && out_ready));

  assign out_data = sr[SR_W-1 -: BUS_W];

  always_comb begin
    tag_ext = TAG_W'(in_tag);
    enc     = '0;
    unique case (1'b1)
      (in_tag == 3'd3): enc = SR_W'({tag_ext, in_a, in_b});
      (in_tag == 3'd4): enc = SR_W'({tag_ext, PP_W'(in_val)});
      default:          enc = SR_W'({tag_ext, {PP_W{1'b0}}});
    endcase
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state      <= IDLE;
      sr         <= '0;
      beat_idx   <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      term_cnt   <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      sr         <= '0;
      beat_idx   <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      term_cnt   <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (accept && !legal) begin
        err_pulse  <= 1'b1;
        err_sticky <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept && legal) begin
            sr        <= enc;
            beat_idx  <= '0;
            state     <= EMIT;
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_last  <= ONE_BEAT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!out_last) begin
              sr        <= sr << BUS_W;
              beat_idx  <= beat_idx + BI_W'(1);
              out_first <= 1'b0;
              out_last  <= ((beat_idx + BI_W'(1)) == LAST_IDX);
            end else begin
              term_cnt <= term_cnt + CNT_W'(1);
              if (accept && legal) begin
                sr        <= enc;
                beat_idx  <= '0;
                out_valid <= 1'b1;
                out_first <= 1'b1;
                out_last  <= ONE_BEAT;
              end else begin
                state     <= IDLE;
                sr        <= '0;
                beat_idx  <= '0;
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_machine_term_serializer.sv
// Bench for machine_term_serializer: directed scenarios plus random
// traffic against a queue-of-beats reference model.
module tb_machine_term_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_tag;
  logic [29:0] in_a;
  logic [29:0] in_b;
  logic [31:0] in_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;
  logic [15:0] term_cnt;
  logic        err_pulse;
  logic        err_sticky;

  logic        clr2;
  logic        in_valid2;
  logic        in_ready2;
  logic [2:0]  in_tag2;
  logic [15:0] in_a2;
  logic [15:0] in_b2;
  logic [31:0] in_val2;
  logic        out_valid2;
  logic        out_ready2;
  logic [63:0] out_data2;
  logic        out_first2;
  logic        out_last2;
  logic [1:0]  term_cnt2;
  logic        err_pulse2;
  logic        err_sticky2;

  machine_term_serializer dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clr             (clr),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_tag          (in_tag),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_val          (in_val),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_first       (out_first),
    .out_last        (out_last),
    .term_cnt        (term_cnt),
    .err_pulse       (err_pulse),
    .err_sticky      (err_sticky)
  );

  machine_term_serializer #(
    .PTR_W(16), .OUT_W(32), .TAG_W(4), .BUS_W(64), .CNT_W(2)
  ) dut1b (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .clr             (clr2),
    .in_valid        (in_valid2),
    .in_ready        (in_ready2),
    .in_tag          (in_tag2),
    .in_a            (in_a2),
    .in_b            (in_b2),
    .in_val          (in_val2),
    .out_valid       (out_valid2),
    .out_ready       (out_ready2),
    .out_data        (out_data2),
    .out_first       (out_first2),
    .out_last        (out_last2),
    .term_cnt        (term_cnt2),
    .err_pulse       (err_pulse2),
    .err_sticky      (err_sticky2)
  );

  typedef struct {
    logic [31:0] data;
    bit          first;
    bit          last;
  } beat_t;

  beat_t       q[$];
  int unsigned cnt_m;
  bit          pulse_m;
  bit          sticky_m;
  bit          acc_m;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_term(input logic [2:0] t, input logic [29:0] a,
                           input logic [29:0] b, input logic [31:0] v);
    logic [63:0] e;
    e = 64'(t) * (64'd1 << 60);
    if (t == 3'd3) e = e + 64'(a) * (64'd1 << 30) + 64'(b);
    if (t == 3'd4) e = e + 64'(v);
    q.push_back('{data: e[63:32], first: 1'b1, last: 1'b0});
    q.push_back('{data: e[31:0],  first: 1'b0, last: 1'b1});
  endtask

  task automatic cycle(input bit v, input logic [2:0] t,
                       input logic [29:0] a, input logic [29:0] b,
                       input logic [31:0] val, input bit ordy, input bit c);
    bit rdy_m;
    @(negedge clk);
    chk("term_cnt",   64'(term_cnt),   64'(cnt_m));
    chk("err_pulse",  64'(err_pulse),  64'(pulse_m));
    chk("err_sticky", 64'(err_sticky), 64'(sticky_m));
    chk("out_valid",  64'(out_valid),  64'(q.size() != 0));
    in_valid  = v;
    in_tag    = t;
    in_a      = a;
    in_b      = b;
    in_val    = val;
    out_ready = ordy;
    clr       = c;
    #1;
    rdy_m = !c && (q.size() == 0 || (q.size() == 1 && ordy));
    chk("in_ready", 64'(in_ready), 64'(rdy_m));
    if (q.size() != 0) begin
      chk("out_data",  64'(out_data),  64'(q[0].data));
      chk("out_first", 64'(out_first), 64'(q[0].first));
      chk("out_last",  64'(out_last),  64'(q[0].last));
    end
    pulse_m = 1'b0;
    acc_m   = v && rdy_m;
    if (c) begin
      q.delete();
      cnt_m    = 0;
      sticky_m = 1'b0;
    end else begin
      if (q.size() != 0 && ordy) begin
        if (q[0].last) cnt_m = (cnt_m + 1) % 65536;
        q.delete(0);
      end
      if (acc_m) begin
        if (t <= 3'd4) push_term(t, a, b, val);
        else begin
          pulse_m  = 1'b1;
          sticky_m = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic send(input logic [2:0] t, input logic [29:0] a,
                      input logic [29:0] b, input logic [31:0] val);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, t, a, b, val, 1'b1, 1'b0);
      if (acc_m) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: got no accept expected accept");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp2[5];
    n_cmp = 0;
    n_bad = 0;
    cnt_m = 0;
    pulse_m = 0;
    sticky_m = 0;
    acc_m = 0;
    rstn = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    in_tag = '0;
    in_a = '0;
    in_b = '0;
    in_val = '0;
    out_ready = 1'b1;
    clr2 = 1'b0;
    in_valid2 = 1'b0;
    in_tag2 = 3'd3;
    in_a2 = '0;
    in_b2 = '0;
    in_val2 = '0;
    out_ready2 = 1'b1;

    #12;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_term_cnt",  64'(term_cnt),  64'd0);
    @(negedge clk);
    rstn = 1'b1;

    send(3'd0, '0, '0, '0);
    send(3'd1, '0, '0, '0);
    idle(3, 1'b1);

    send(3'd3, 30'h1, 30'h2, '0);
    idle(3, 1'b1);

    send(3'd4, '0, '0, 32'hDEADBEEF);
    idle(3, 1'b0);
    idle(3, 1'b1);

    cycle(1'b1, 3'd6, '0, '0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    send(3'd2, '0, '0, '0);
    idle(3, 1'b1);
    cycle(1'b1, 3'd0, '0, '0, '0, 1'b1, 1'b1);
    idle(2, 1'b1);

    send(3'd3, 30'h155, 30'h2AA, '0);
    idle(1, 1'b1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid",  64'(out_valid),  64'd0);
    chk("arst_out_data",   64'(out_data),   64'd0);
    chk("arst_out_first",  64'(out_first),  64'd0);
    chk("arst_out_last",   64'(out_last),   64'd0);
    chk("arst_term_cnt",   64'(term_cnt),   64'd0);
    chk("arst_in_ready",   64'(in_ready),   64'd0);
    chk("arst_err_sticky", 64'(err_sticky), 64'd0);
    q.delete();
    cnt_m = 0;
    pulse_m = 1'b0;
    sticky_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle(3, 1'b1);

    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom % 2), 3'($urandom % 8), 30'($urandom),
            30'($urandom), $urandom, 1'(($urandom % 4) != 0),
            1'(($urandom % 60) == 0));
    end
    idle(4, 1'b1);

    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 1)
        chk("b1_term_cnt", 64'(term_cnt2), 64'((k - 1) % 4));
      if (k >= 1 && k <= 5) begin
        chk("b1_out_valid", 64'(out_valid2), 64'd1);
        chk("b1_out_data",  out_data2,       exp2[k-1]);
        chk("b1_out_first", 64'(out_first2), 64'd1);
        chk("b1_out_last",  64'(out_last2),  64'd1);
      end
      if (k == 6) chk("b1_drained", 64'(out_valid2), 64'd0);
      if (k < 5) begin
        in_valid2 = 1'b1;
        in_tag2   = 3'd3;
        in_a2     = 16'($urandom);
        in_b2     = 16'($urandom);
        exp2[k]   = 64'd3 * (64'd1 << 32) + 64'(in_a2) * 64'd65536 +
                    64'(in_b2);
        #1;
        chk("b1_in_ready", 64'(in_ready2), 64'd1);
      end else begin
        in_valid2 = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
